// File: rtl/simple_ntt_pkg.sv
// rtl/simple_ntt_pkg.sv - shared FSM state codes, output-order mode codes and bit-reverse helper
// Contents:
//   ST_IDLE / ST_LOAD / ST_DRAIN  frame controller state encoding
//   MODE_NAT / MODE_BREV / MODE_REV / MODE_RSVD  output order codes
//   bit_rev(v, n)  reverse the low n bits of v (n in 1..10), upper bits zero
package simple_ntt_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] MODE_NAT  = 2'd0;
  localparam logic [1:0] MODE_BREV = 2'd1;
  localparam logic [1:0] MODE_REV  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Reverse all ten bits, then shift the reversed low field back down to bit 0.
  function automatic logic [9:0] bit_rev(input logic [9:0] v, input int n);
    logic [9:0] r;
    r = {<<{v}};
    return r >> (10 - n);
  endfunction

endpackage

// File: rtl/ntt_frame_ram.sv
// rtl/ntt_frame_ram.sv - DEPTH x DATA_W frame buffer, one write port, one synchronous read port
// Ports:
//   clk, reset        clock; asynchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr     read request; rd_data updates on the next rising edge
//   rd_data           registered read data, holds while rd_en is low
module ntt_frame_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // Storage array is deliberately left out of reset.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register doubles as the block's output data register, so it
  // holds its value whenever no new word is requested.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/simple_ntt_stream.sv
// rtl/simple_ntt_stream.sv - frame buffer that reduces input samples and replays them in a selectable order
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start, mode           begin a frame (IDLE only); output order latched on start
//   in_valid/in_data/in_ready     input sample stream (accepted in LOAD)
//   out_valid/out_data/out_ready  output sample stream (registered, DRAIN)
//   idle                  high in IDLE
//   done                  one-cycle pulse after the last output handshake
//   range_err             sticky: a sample of the current frame was >= 2*MODULUS
module simple_ntt_stream
  import simple_ntt_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH_LOG2 = 2,
  parameter int unsigned MODULUS    = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              idle,
  output logic              done,
  output logic              range_err
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [AW-1:0] WR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   RD_END  = (AW + 1)'(DEPTH);
  localparam logic [DATA_W:0] MOD_EXT     = (DATA_W + 1)'(MODULUS);
  localparam logic [DATA_W:0] TWO_MOD_EXT = MOD_EXT << 1;

  logic [1:0]        state_q,     state_d;
  logic [1:0]        mode_q,      mode_d;
  logic [AW-1:0]     wr_idx_q,    wr_idx_d;
  logic [AW:0]       rd_idx_q,    rd_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q,      done_d;
  logic              range_err_q, range_err_d;

  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_lin;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W:0]   in_ext;

  // Single conditional subtraction; one extra bit keeps the compare exact
  // when MODULUS sits near the top of the DATA_W range.
  assign in_ext  = {1'b0, in_data};
  assign wr_data = (in_ext >= MOD_EXT) ? DATA_W'(in_ext - MOD_EXT) : in_data;

  assign rd_lin = rd_idx_q[AW-1:0];

  always_comb begin
    rd_addr = rd_lin;
    case (mode_q)
      MODE_BREV: rd_addr = AW'(bit_rev(10'(rd_lin), AW));
      MODE_REV:  rd_addr = WR_LAST - rd_lin;
      default:   rd_addr = rd_lin;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    range_err_d = range_err_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Reserved order code behaves as natural order.
          mode_d      = (mode == MODE_RSVD) ? MODE_NAT : mode;
          wr_idx_d    = '0;
          rd_idx_d    = '0;
          range_err_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (in_ext >= TWO_MOD_EXT) begin
            range_err_d = 1'b1;
          end
          if (wr_idx_q == WR_LAST) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // rd_idx counts words fetched into the output register; a fetch is
        // allowed whenever that register is empty or being consumed.
        if ((rd_idx_q != RD_END) && (!out_valid_q || out_ready)) begin
          rd_en       = 1'b1;
          rd_idx_d    = rd_idx_q + 1'b1;
          out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
          // Only reachable once every word has been fetched: this is the
          // final handshake of the frame.
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NAT;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
    end
  end

  ntt_frame_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_idx_q),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign range_err = range_err_q;
  assign idle      = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);

endmodule

// File: doc/simple_ntt_stream.md
SIMPLE_NTT_STREAM -- requirements
Module: simple_ntt_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2; frame depth DEPTH = 2**DEPTH_LOG2 (range 1..10).
REQ-003 SHALL have parameter MODULUS, default 17; reduction modulus, 1 < MODULUS < 2**DATA_W.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  begin a frame; sampled only in IDLE.
REQ-007 mode  input  2  output order: 0 natural, 1 bit-reversed, 2 reverse, 3 reserved (treated as 0); latched on accepted start.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_data  input  DATA_W  input sample.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_data  output  DATA_W  output sample.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 idle  output  1  high only in IDLE.
REQ-015 done  output  1  one-cycle pulse after the last output handshake.
REQ-016 range_err  output  1  sticky; a frame sample was >= 2*MODULUS.

Function
REQ-017 SHALL implement three states: IDLE, LOAD, DRAIN.
REQ-018 IDLE: idle=1, in_ready=0, out_valid=0; start=1 latches mode, clears wr/rd counters and range_err, moves to LOAD next cycle.
REQ-019 LOAD: in_ready=1; each in_valid&&in_ready handshake stores one sample at address wr_idx and increments wr_idx.
REQ-020 Stored value SHALL be in_data - MODULUS if in_data >= MODULUS, else in_data; comparisons in DATA_W+1 bits, result truncated to DATA_W.
REQ-021 in_data >= 2*MODULUS SHALL set range_err (value still stored per REQ-020).
REQ-022 On the DEPTH-th handshake the state SHALL move to DRAIN; in_ready deasserts the following cycle.
REQ-023 DRAIN: read address SHALL be rd_idx (mode 0), bit-reverse of rd_idx over DEPTH_LOG2 bits (mode 1), DEPTH-1-rd_idx (mode 2).
REQ-024 out_data/out_valid SHALL be registered; first out_valid asserts exactly one cycle after entering DRAIN.
REQ-025 A new word SHALL load into the output register when !out_valid || out_ready; while out_valid && !out_ready, out_data and out_valid SHALL hold.
REQ-026 After the DEPTH-th output handshake: out_valid=0, done=1 for one cycle, state returns to IDLE.
REQ-027 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored (no storage).
REQ-028 Sustained throughput SHALL be one sample per cycle in LOAD and one per cycle in DRAIN with out_ready held high.
REQ-029 A new start accepted in the IDLE cycle after done SHALL begin a fresh frame without restriction.

Reset
REQ-030 reset SHALL force IDLE, out_valid=0, out_data=0, done=0, range_err=0, counters and latched mode to 0, at any time including mid-LOAD or mid-DRAIN.
REQ-031 Buffer memory SHALL NOT be reset; a partial frame is discarded.

Structure
REQ-032 State encoding, mode codes and a bit-reverse function SHALL live in a shared package simple_ntt_pkg.
REQ-033 Buffer SHALL be a sub-module ntt_frame_ram (1 write port, 1 synchronous read port, DEPTH x DATA_W).
REQ-034 Address permutation and modular reduction SHALL remain in the top-level block.

Verification (DEPTH_LOG2=2, MODULUS=17, DATA_W=32)
REQ-035 mode 0, inputs 1,2,3,4, out_ready=1 -> out 1,2,3,4 on consecutive cycles, done pulse, idle=1.
REQ-036 mode 1, inputs 10,11,12,13 -> out 10,12,11,13; mode 2 same inputs -> 13,12,11,10.
REQ-037 mode 0, inputs 17,20,33,40 -> out 0,3,16,23; range_err=1 after the 4th handshake, cleared by next start.
REQ-038 mode 0, out_ready low for 3 cycles at the 2nd output -> out_data held stable, no sample lost or duplicated.
REQ-039 reset pulsed after 2 loads -> IDLE next cycle, all outputs 0; next frame 5,6,7,8 -> out 5,6,7,8.
REQ-040 start and in_valid asserted during DRAIN -> ignored; output sequence and done timing unchanged.
